gamepad_conditioner: RTL
========================

// Module: gamepad_conditioner
// PURPOSE
//  Upstream input stage for the maze/robot top level. Conditions raw gamepad lines before they
//  reach the maze memory: synchronises each button to `clock`, debounces it and emits clean levels.
//  Drives the memory's gamepad_input bus and its single-step manual_clock strobe.
// PARAMETERS
//  NUM_BTN         12     number of gamepad lines
//  TICK_DIV        50000  clock cycles per debounce sample tick (>=2)
//  STABLE_SAMPLES  4      consecutive disagreeing ticks needed to commit a new level (>=1)
//  RAW_ACTIVE_LOW  1      1: raw line low = pressed; 0: raw line high = pressed
//  STEP_IDX        11     button index whose press generates manual_clock
//  PULSE_LEN       2      manual_clock high time in clock cycles (>=1)
// PORTS
//  clock          in   1        system clock, single domain
//  reset          in   1        synchronous, active-low reset
//  gamepad_raw    in   NUM_BTN  asynchronous raw button lines
//  gamepad_input  out  NUM_BTN  debounced levels, 1 = pressed (to maze memory)
//  gamepad_press  out  NUM_BTN  1-cycle strobe on each debounced press (0->1)
//  manual_clock   out  1        step strobe for the maze memory, PULSE_LEN cycles wide
//  sample_tick    out  1        1-cycle debounce sample strobe (debug/observability)
// BEHAVIOUR
//  - Reset (reset==0 at a rising edge): gamepad_input=0, gamepad_press=0, manual_clock=0,
//    sample_tick=0, prescaler=0, all debounce counters=0, both sync stages load released level.
//  - Polarity: pressed = RAW_ACTIVE_LOW ? ~raw : raw, applied after the 2-FF synchroniser.
//  - Prescaler: counts 0..TICK_DIV-1, wraps to 0; sample_tick=1 for the cycle it equals TICK_DIV-1.
//  - Per button, on sample_tick only: if synced!=committed, cnt++; else cnt=0.
//    When cnt would reach STABLE_SAMPLES: committed<=synced, cnt<=0. No change between ticks.
//  - Commit is registered: gamepad_input changes the cycle after the committing tick.
//  - gamepad_press[i]=1 in exactly that cycle when committed went 0->1; release gives no strobe.
//  - Glitch shorter than one tick spacing, or returning before STABLE_SAMPLES ticks, never commits.
//  - Latency raw->gamepad_input: 2 sync cycles + STABLE_SAMPLES ticks + 1 cycle, worst case.
//  - manual_clock: pulse counter loaded with PULSE_LEN on gamepad_press[STEP_IDX];
//    high while counter!=0. A press arriving while the counter is non-zero is ignored (no extend,
//    no restart).
//  - Simultaneous presses on several buttons: all strobes in the same cycle, independent.
//  - reset low mid-debounce or mid-pulse: all state cleared on that edge; any pending press is
//    dropped. After reset, a button already held commits after the normal STABLE_SAMPLES ticks.
//  - Counter widths: $clog2(TICK_DIV), $clog2(STABLE_SAMPLES+1), $clog2(PULSE_LEN+1); no overflow.
// STRUCTURE
//  - Shared package: button index constants (STEP button = 11) and default timing constants,
//    reused by the maze memory's gamepad decode.
//  - Sub-module debounce_cell (1 bit): sync FFs, polarity, counter, committed level, press strobe.
//    Generated NUM_BTN times. Prescaler and manual_clock pulse logic live in the top of this block.
// TESTING  (TICK_DIV=4, STABLE_SAMPLES=3, PULSE_LEN=2, RAW_ACTIVE_LOW=1)
//  - Reset: hold reset=0 for 3 cycles with raw=12'h000 -> all outputs 0; release -> ticks at
//    cycles 3,7,11...
//  - Clean press: raw[0] 1->0 held -> gamepad_input[0]=1 one cycle after 3rd agreeing tick;
//    gamepad_press[0] high 1 cycle.
//  - Glitch: raw[2] low for 5 cycles, then high -> gamepad_input[2] stays 0, no press strobe.
//  - Step: press button 11 -> manual_clock high exactly 2 cycles. Re-press held through the pulse
//    -> no extra pulse.
//  - Multi/release: buttons 3 and 7 pressed together -> both strobes in the same cycle.
//    Release -> input returns to 0 after 3 ticks, no strobe.
//  - Reset mid-op: reset=0 during 2nd tick of a press and during a pulse -> outputs 0 next cycle;
//    held button re-commits after 3 ticks post-reset.

Source files
------------

// File: rtl/gamepad_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// gamepad_conditioner_pkg
//   Shared constants for the gamepad input path. The button indices and the
//   default timing values are also used by the maze memory's gamepad decode,
//   so both sides agree on which line is the single-step button.
//   Contents:
//     NUM_BTN_DEF, BTN_STEP         - bus width and step-button index
//     TICK_DIV_DEF, STABLE_SAMPLES_DEF, PULSE_LEN_DEF, RAW_ACTIVE_LOW_DEF
//                                   - default debounce / pulse timing
//     to_pressed()                  - raw line level -> "pressed" (1 = pressed)
// ---------------------------------------------------------------------------
package gamepad_conditioner_pkg;

    localparam int NUM_BTN_DEF        = 12;
    localparam int BTN_STEP           = 11;
    localparam int TICK_DIV_DEF       = 50000;
    localparam int STABLE_SAMPLES_DEF = 4;
    localparam int PULSE_LEN_DEF      = 2;
    localparam int RAW_ACTIVE_LOW_DEF = 1;

    // Map a synchronised raw line to the pressed sense (1 = pressed).
    function automatic logic to_pressed(input logic level, input logic active_low);
        return active_low ? ~level : level;
    endfunction

endpackage

// File: rtl/gamepad_conditioner_debounce_cell.sv
// ---------------------------------------------------------------------------
// gamepad_conditioner_debounce_cell
//   One button: 2-FF synchroniser, polarity fix-up, tick-based debounce
//   counter, registered committed level and a one-cycle press strobe.
//   Ports:
//     clock        in  system clock
//     reset        in  synchronous, active-low reset
//     raw          in  asynchronous raw button line
//     sample_tick  in  debounce sample strobe from the shared prescaler
//     level        out debounced level, 1 = pressed
//     press        out 1-cycle strobe when level goes 0->1
// ---------------------------------------------------------------------------
module gamepad_conditioner_debounce_cell
    import gamepad_conditioner_pkg::*;
#(
    parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
    parameter int RAW_ACTIVE_LOW = RAW_ACTIVE_LOW_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic sample_tick,
    output logic level,
    output logic press
);

    localparam int   CW       = $clog2(STABLE_SAMPLES + 1);
    localparam logic ACT_LOW  = (RAW_ACTIVE_LOW != 0);
    // Raw line value that means "released"; the synchroniser resets to it so
    // that leaving reset never looks like an edge.
    localparam logic RELEASED = ACT_LOW;

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic [CW-1:0] cnt;

    assign pressed = to_pressed(sync2, ACT_LOW);

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sample_tick) begin
                if (pressed != level) begin
                    // The tick that would bring cnt to STABLE_SAMPLES commits
                    // directly, so cnt never has to hold that value.
                    if (cnt == CW'(STABLE_SAMPLES - 1)) begin
                        level <= pressed;
                        press <= pressed;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/gamepad_conditioner.sv
// ---------------------------------------------------------------------------
// gamepad_conditioner
//   Input stage in front of the maze memory: synchronises and debounces every
//   gamepad line, reports clean levels and press strobes, and turns presses of
//   the step button into a fixed-width manual_clock pulse.
//   Ports:
//     clock          in  system clock, single domain
//     reset          in  synchronous, active-low reset
//     gamepad_raw    in  [NUM_BTN] asynchronous raw button lines
//     gamepad_input  out [NUM_BTN] debounced levels, 1 = pressed
//     gamepad_press  out [NUM_BTN] 1-cycle strobe per debounced press
//     manual_clock   out step strobe, PULSE_LEN cycles wide
//     sample_tick    out 1-cycle debounce sample strobe
// ---------------------------------------------------------------------------
module gamepad_conditioner
    import gamepad_conditioner_pkg::*;
#(
    parameter int NUM_BTN        = NUM_BTN_DEF,
    parameter int TICK_DIV       = TICK_DIV_DEF,
    parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
    parameter int RAW_ACTIVE_LOW = RAW_ACTIVE_LOW_DEF,
    parameter int STEP_IDX       = BTN_STEP,
    parameter int PULSE_LEN      = PULSE_LEN_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] gamepad_raw,
    output logic [NUM_BTN-1:0] gamepad_input,
    output logic [NUM_BTN-1:0] gamepad_press,
    output logic               manual_clock,
    output logic               sample_tick
);

    localparam int PW  = $clog2(TICK_DIV);
    localparam int PLW = $clog2(PULSE_LEN + 1);

    logic [PW-1:0]  prescaler;
    logic [PLW-1:0] pulse_cnt;

    // Shared sample-tick prescaler.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (prescaler == PW'(TICK_DIV - 1)) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign sample_tick = (prescaler == PW'(TICK_DIV - 1));

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        gamepad_conditioner_debounce_cell #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
        ) u_cell (
            .clock       (clock),
            .reset       (reset),
            .raw         (gamepad_raw[i]),
            .sample_tick (sample_tick),
            .level       (gamepad_input[i]),
            .press       (gamepad_press[i])
        );
    end

    // Step pulse: a press only loads the counter when it is idle, so a press
    // landing inside an active pulse neither extends nor restarts it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pulse_cnt <= '0;
        end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - PLW'(1);
        end else if (gamepad_press[STEP_IDX]) begin
            pulse_cnt <= PLW'(PULSE_LEN);
        end
    end

    assign manual_clock = (pulse_cnt != '0);

endmodule
